instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multi-cycle MIPS fetch stage directly upstream of the register file.
//  Holds the PC and fetches one word per instruction over a read/waitrequest memory port.
//  Presents the instruction to the register file together with valid and reg_dst.
//  Waits for end_instr from downstream before advancing the PC.
//  Handles sequential advance, redirect (branch/jump) and halt on jump to address 0.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC value loaded on reset
//  HALT_ADDR     32'h00000000  next-PC value that stops the CPU
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  address      out  32  memory byte address; equals pc while read=1
//  read         out  1   memory read strobe
//  waitrequest  in   1   memory stall; transfer completes on a cycle with read=1 and waitrequest=0
//  readdata     in   32  instruction word, valid on the completing cycle
//  Instruction  out  32  latched instruction word to the register file
//  valid        out  1   Instruction is valid and held stable
//  reg_dst      out  1   1 when Instruction[31:26]==6'b000000 (R-type), else 0
//  end_instr    in   1   downstream retired the current instruction
//  redirect     in   1   sampled with end_instr; take redirect_pc instead of pc+4
//  redirect_pc  in   32  branch/jump target
//  active       out  1   CPU running; 0 in reset and after halt/fault
//  fault        out  1   sticky; set on a misaligned redirect target
//  retired      out  32  count of retired instructions, wraps modulo 2^32
// BEHAVIOUR
//  All outputs are registered; reset takes priority over every other input.
//  Reset values:
//   - pc=RESET_VECTOR, address=RESET_VECTOR
//   - read=0, valid=0, Instruction=0, reg_dst=0
//   - active=0, fault=0, retired=0
//   - state=FETCH
//  First cycle after reset deasserts: active=1, read=1.
//  States:
//   FETCH:
//    - read=1, address=pc, held stable while waitrequest=1; no timeout.
//    - On the cycle read=1 and waitrequest=0:
//      Instruction<=readdata, reg_dst<=(readdata[31:26]==0), valid<=1, read<=0, go to EXEC.
//    - end_instr is ignored in FETCH.
//   EXEC:
//    - Instruction, reg_dst and valid are held until end_instr=1.
//    - waitrequest and readdata are ignored.
//    - On end_instr=1:
//      valid<=0 next cycle; retired<=retired+1.
//      npc = redirect ? redirect_pc : pc+32'd4 (modulo 2^32).
//    - If redirect=1 and redirect_pc[1:0]!=0: fault<=1, active<=0, go to HALTED; pc unchanged.
//    - Else if npc==HALT_ADDR: pc<=npc, active<=0, go to HALTED.
//    - Else: pc<=npc, go to FETCH; read=1 with the new address on the next cycle.
//   HALTED:
//    - read=0, valid=0, active=0.
//    - All inputs ignored until reset.
//  Latency:
//   - Zero-wait fetch: read high 1 cycle; valid rises the cycle after completion.
//   - end_instr to next read: 1 cycle.
//  PC wrap: 32'hFFFFFFFC+4 = 0, which is HALT_ADDR and therefore halts.
//  Reset mid-fetch or mid-exec: pending read is abandoned (read=0 next cycle) and retired clears.
// TESTING
//  1. reset 2 cycles, zero-wait memory returning 32'h00851020 -> read=1 at address BFC00000;
//     next cycle valid=1, Instruction=00851020, reg_dst=1.
//  2. waitrequest=1 for 5 cycles -> read and address=BFC00000 stable 6 cycles;
//     Instruction latched only on completion.
//  3. I-type 32'h24420001, end_instr with redirect=0 -> reg_dst=0, retired=1;
//     next read at BFC00004 one cycle later.
//  4. end_instr, redirect=1, redirect_pc=BFC00100 -> next fetch at BFC00100;
//     redirect_pc=BFC00102 -> fault=1, active=0, read stays 0.
//  5. redirect to 0 -> active=0, HALTED;
//     further end_instr/waitrequest activity causes no reads and retired is unchanged.
//  6. reset asserted while waitrequest=1 mid-fetch -> next cycle read=0, valid=0;
//     restart fetch at BFC00000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-cycle MIPS fetch stage feeding the register file.
// Fetches one word per instruction and waits for end_instr before advancing the PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic [31:0] Instruction,
    output logic        valid,
    output logic        reg_dst,
    input  logic        end_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        active,
    output logic        fault,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, retired_q, retired_d, npc;
    logic        read_q, read_d, valid_q, valid_d, reg_dst_q, reg_dst_d;
    logic        active_q, active_d, fault_q, fault_d, bad_tgt, stop;
    assign npc     = redirect ? redirect_pc : pc_q + 32'd4;
    assign bad_tgt = redirect && redirect_pc[1:0] != 2'b00;
    assign stop    = bad_tgt || npc == HALT_ADDR;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VECTOR;
            instr_q   <= '0;
            retired_q <= '0;
            read_q    <= 1'b0;
            valid_q   <= 1'b0;
            reg_dst_q <= 1'b0;
            active_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            read_q    <= read_d;
            valid_q   <= valid_d;
            reg_dst_q <= reg_dst_d;
            active_q  <= active_d;
            fault_q   <= fault_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = (read_q && !waitrequest) ? EXEC : FETCH;
            EXEC:    state_d = !end_instr ? EXEC : stop ? HALTED : FETCH;
            default: state_d = HALTED;
        endcase
    end
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        read_d    = read_q;
        valid_d   = valid_q;
        reg_dst_d = reg_dst_q;
        active_d  = active_q;
        fault_d   = fault_q;
        case (state_q)
            FETCH: begin
                // read_q low in FETCH only happens on the first cycle out of reset
                if (!read_q) begin
                    read_d   = 1'b1;
                    active_d = 1'b1;
                end else if (!waitrequest) begin
                    instr_d   = readdata;
                    reg_dst_d = readdata[31:26] == 6'b000000;
                    valid_d   = 1'b1;
                    read_d    = 1'b0;
                end
            end
            EXEC: begin
                if (end_instr) begin
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    fault_d   = fault_q | bad_tgt;
                    pc_d      = bad_tgt ? pc_q : npc;
                    active_d  = !stop;
                    read_d    = !stop;
                end
            end
            default: begin
                read_d   = 1'b0;
                valid_d  = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end
    assign address     = pc_q;
    assign read        = read_q;
    assign Instruction = instr_q;
    assign valid       = valid_q;
    assign reg_dst     = reg_dst_q;
    assign active      = active_q;
    assign fault       = fault_q;
    assign retired     = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, stall, retire, redirect, fault, halt and reset.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1, waitrequest = 1'b0, end_instr = 1'b0, redirect = 1'b0;
    logic [31:0] readdata = '0, redirect_pc = '0, address, Instruction, retired;
    logic        read, valid, reg_dst, active, fault;
    int          total = 0, bad = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .waitrequest(waitrequest),
        .readdata(readdata), .Instruction(Instruction), .valid(valid), .reg_dst(reg_dst),
        .end_instr(end_instr), .redirect(redirect), .redirect_pc(redirect_pc),
        .active(active), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic retire(input logic rd, input logic [31:0] tgt);
        end_instr = 1'b1;
        redirect = rd;
        redirect_pc = tgt;
        step();
        end_instr = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_read", read, 0);
        chk("rst_valid", valid, 0);
        chk("rst_active", active, 0);
        chk("rst_addr", address, 32'hBFC00000);
        chk("rst_instr", Instruction, 0);
        chk("rst_retired", retired, 0);
        chk("rst_fault", fault, 0);
        // zero-wait fetch of an R-type word
        reset = 1'b0;
        readdata = 32'h00851020;
        step();
        chk("t1_read", read, 1);
        chk("t1_active", active, 1);
        chk("t1_addr", address, 32'hBFC00000);
        step();
        chk("t1_valid", valid, 1);
        chk("t1_instr", Instruction, 32'h00851020);
        chk("t1_regdst", reg_dst, 1);
        chk("t1_read_off", read, 0);
        step();
        chk("t1_hold", valid, 1);
        // sequential retire, then a 5-cycle stalled fetch
        waitrequest = 1'b1;
        readdata = 32'hDEADBEEF;
        retire(1'b0, 32'h0);
        chk("t3_retired", retired, 1);
        chk("t3_read", read, 1);
        chk("t3_addr", address, 32'hBFC00004);
        chk("t3_valid", valid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_read", read, 1);
            chk("t2_addr", address, 32'hBFC00004);
            chk("t2_instr", Instruction, 32'h00851020);
        end
        waitrequest = 1'b0;
        readdata = 32'h24420001;
        step();
        chk("t2_valid", valid, 1);
        chk("t2_instr_done", Instruction, 32'h24420001);
        chk("t3_regdst", reg_dst, 0);
        // aligned redirect then misaligned redirect
        readdata = 32'h00000020;
        retire(1'b1, 32'hBFC00100);
        chk("t4_read", read, 1);
        chk("t4_addr", address, 32'hBFC00100);
        chk("t4_retired", retired, 2);
        step();
        chk("t4_instr", Instruction, 32'h00000020);
        chk("t4_regdst", reg_dst, 1);
        retire(1'b1, 32'hBFC00102);
        chk("t4_fault", fault, 1);
        chk("t4_active", active, 0);
        chk("t4_read_off", read, 0);
        chk("t4_pc_kept", address, 32'hBFC00100);
        chk("t4_retired3", retired, 3);
        step();
        chk("t4_read_stays", read, 0);
        // redirect to address 0 halts
        reset = 1'b1;
        step();
        step();
        chk("t5_fault_clr", fault, 0);
        reset = 1'b0;
        readdata = 32'h24420001;
        step();
        step();
        chk("t5_valid", valid, 1);
        retire(1'b1, 32'h0);
        chk("t5_active", active, 0);
        chk("t5_read", read, 0);
        chk("t5_addr", address, 0);
        chk("t5_retired", retired, 1);
        chk("t5_fault", fault, 0);
        end_instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_read", read, 0);
            chk("t5_ret_same", retired, 1);
            chk("t5_no_valid", valid, 0);
        end
        end_instr = 1'b0;
        // reset in the middle of a stalled fetch
        reset = 1'b1;
        step();
        reset = 1'b0;
        waitrequest = 1'b1;
        step();
        step();
        chk("t6_pre_read", read, 1);
        reset = 1'b1;
        step();
        chk("t6_read", read, 0);
        chk("t6_valid", valid, 0);
        chk("t6_active", active, 0);
        chk("t6_addr", address, 32'hBFC00000);
        reset = 1'b0;
        waitrequest = 1'b0;
        readdata = 32'h00851020;
        step();
        chk("t6_restart", read, 1);
        chk("t6_restart_addr", address, 32'hBFC00000);
        // PC wraps from FFFFFFFC to 0 and halts
        step();
        retire(1'b1, 32'hFFFFFFFC);
        chk("wrap_addr", address, 32'hFFFFFFFC);
        chk("wrap_read", read, 1);
        step();
        retire(1'b0, 32'h0);
        chk("wrap_halt", active, 0);
        chk("wrap_pc", address, 0);
        chk("wrap_read_off", read, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
